// File: rtl/ram_neg_pkg.sv
// ram_neg_pkg: shared widths and FSM state type for the RAM negate sequencer.
package ram_neg_pkg;
  localparam int ADR_W  = 6;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 7;
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
endpackage

// File: rtl/ram_neg_csum.sv
// ram_neg_csum: mod-256 byte accumulator with synchronous clear and enable.
import ram_neg_pkg::*;
module ram_neg_csum (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (clr) sum <= '0;
    else if (en) sum <= sum + din;
endmodule

// File: rtl/ram_neg_seq.sv
// ram_neg_seq: walks an address range of a 64x8 RAM replacing each byte with its two's complement.
// Define RAM_NEG_CSUM_EN to accumulate a checksum of the original bytes.
import ram_neg_pkg::*;
module ram_neg_seq (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADR_W-1:0]  start_adr,
  input  logic [ADR_W-1:0]  end_adr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  count,
  output logic [ADR_W-1:0]  mem_adr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] csum
);
  state_t state, nxt;
  logic [ADR_W-1:0] cur_adr, last_adr;
  logic [DATA_W-1:0] neg;
  logic accept, last;
  assign accept = state == IDLE && start;
  assign last = cur_adr == last_adr;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? RD : IDLE;
      RD:      nxt = abort ? DONE : CAP;
      CAP:     nxt = abort ? DONE : WR;
      WR:      nxt = (abort || last) ? DONE : RD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cur_adr  <= '0;
      last_adr <= '0;
      neg      <= '0;
      count    <= '0;
      aborted  <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        cur_adr  <= start_adr;
        last_adr <= end_adr;
        count    <= '0;
        aborted  <= 1'b0;
      end
      if (state == CAP) neg <= ~mem_rdata + 1'b1;
      if (state == WR) begin
        count <= count + 1'b1;
        if (!abort && !last) cur_adr <= cur_adr + 1'b1;
      end
      if (abort && (state == RD || state == CAP || state == WR)) aborted <= 1'b1;
    end
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign mem_rd    = state == RD;
  assign mem_wr    = state == WR;
  assign mem_adr   = (mem_rd || mem_wr) ? cur_adr : '0;
  assign mem_wdata = mem_wr ? neg : '0;
`ifdef RAM_NEG_CSUM_EN
  ram_neg_csum u_csum (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en(state == CAP),
    .din(mem_rdata),
    .sum(csum)
  );
`else
  assign csum = '0;
`endif
endmodule
